// File: rtl/crc_serial_engine_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the bit-serial CRC engine family.
//   crc_state_t   : engine FSM state (IDLE / SHIFT / EMIT)
//   CRC_MODE_GEN  : compute the CRC and shift it out serially
//   CRC_MODE_CHK  : feed data plus received CRC, flag a zero residue
//   BLE_CRC_POLY  : BLE CRC-24 generator x^24+x^10+x^9+x^6+x^4+x^3+x+1
//                   (the x^24 term is implicit)
//   BLE_CRC_INIT  : BLE advertising-channel CRC seed
// -----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } crc_state_t;

  localparam logic CRC_MODE_GEN = 1'b0;
  localparam logic CRC_MODE_CHK = 1'b1;

  localparam logic [23:0] BLE_CRC_POLY = 24'h00065B;
  localparam logic [23:0] BLE_CRC_INIT = 24'h555555;

endpackage : crc_pkg

// File: rtl/crc_serial_engine_lfsr_step.sv
// -----------------------------------------------------------------------------
// crc_lfsr_step
// One Galois, MSB-first CRC update: folds a single data bit into the register.
// Purely combinational, so a parallel engine can chain several instances.
// Parameters:
//   CRC_W : register width (2..32)
//   POLY  : generator polynomial without the x^CRC_W term
// Ports:
//   lfsr      in  CRC_W  current register value
//   data_bit  in  1      incoming data bit
//   next_lfsr out CRC_W  register value after absorbing data_bit
// -----------------------------------------------------------------------------
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 24,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(BLE_CRC_POLY)
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             data_bit,
  output logic [CRC_W-1:0] next_lfsr
);

  logic fb;

  assign fb        = data_bit ^ lfsr[CRC_W-1];
  assign next_lfsr = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule : crc_lfsr_step

// File: rtl/crc_serial_engine.sv
// -----------------------------------------------------------------------------
// crc_serial_engine
// Parametrised bit-serial CRC engine with frame handshake. In generate mode the
// CRC of the frame is frozen on crc_o and shifted out MSB first; in check mode
// the frame is followed by its received CRC and match_o flags a zero residue.
// Default configuration is BLE CRC-24.
//
// Optional build macro:
//   CRC_SEED_PORT_EN : adds seed_i; start_i loads seed_i instead of INIT.
//
// Ports:
//   clk_i        in   1      clock, rising edge
//   rst_n_i      in   1      synchronous, active-low reset
//   start_i      in   1      begin frame: load seed, latch mode_i
//   mode_i       in   1      0 = generate, 1 = check (sampled with start_i)
//   seed_i       in   CRC_W  per-frame seed (only with CRC_SEED_PORT_EN)
//   valid_i      in   1      data_i carries a frame bit
//   data_i       in   1      serial data, MSB first
//   last_i       in   1      current valid bit is the final one
//   busy_o       out  1      frame in progress (SHIFT or EMIT)
//   crc_o        out  CRC_W  CRC of the last completed generate frame
//   crc_bit_o    out  1      serialised CRC bit, MSB first
//   crc_valid_o  out  1      crc_bit_o is valid
//   done_o       out  1      one-cycle pulse at frame completion
//   match_o      out  1      check-mode result, held until the next done_o
// -----------------------------------------------------------------------------
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W = 24,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(BLE_CRC_POLY),
  parameter logic [CRC_W-1:0] INIT  = CRC_W'(BLE_CRC_INIT)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             mode_i,
`ifdef CRC_SEED_PORT_EN
  input  logic [CRC_W-1:0] seed_i,
`endif
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             last_i,
  output logic             busy_o,
  output logic [CRC_W-1:0] crc_o,
  output logic             crc_bit_o,
  output logic             crc_valid_o,
  output logic             done_o,
  output logic             match_o
);

  localparam int IDX_W = $clog2(CRC_W);

  crc_state_t       state;
  logic             mode_q;
  logic [CRC_W-1:0] lfsr;
  logic [IDX_W-1:0] emit_idx;   // index of the crc_o bit currently on crc_bit_o

  logic [CRC_W-1:0] seed_val;
  logic [CRC_W-1:0] step_base;
  logic [CRC_W-1:0] step_next;
  logic             apply_bit;
  logic             complete;
  logic             mode_eff;

`ifdef CRC_SEED_PORT_EN
  assign seed_val = seed_i;
`else
  assign seed_val = INIT;
`endif

  // A bit arriving together with start_i is folded into the fresh seed, so the
  // step always operates on the value the register is about to hold.
  assign step_base = start_i ? seed_val : lfsr;
  assign apply_bit = valid_i & (start_i | (state == SHIFT));
  assign complete  = apply_bit & last_i;
  assign mode_eff  = start_i ? mode_i : mode_q;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .lfsr      (step_base),
    .data_bit  (data_i),
    .next_lfsr (step_next)
  );

  assign busy_o = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values; later assignments in this block deliberately
  // override earlier ones (frame completion wins over plain shifting).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      mode_q      <= CRC_MODE_GEN;
      lfsr        <= INIT;
      emit_idx    <= '0;
      crc_o       <= '0;
      match_o     <= 1'b0;
      crc_bit_o   <= 1'b0;
      crc_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (start_i) begin
        // Restart from any state; an emit in progress is abandoned.
        mode_q      <= mode_i;
        lfsr        <= apply_bit ? step_next : seed_val;
        state       <= SHIFT;
        crc_valid_o <= 1'b0;
        crc_bit_o   <= 1'b0;
      end else begin
        case (state)
          SHIFT: begin
            if (valid_i) lfsr <= step_next;
          end
          EMIT: begin
            if (emit_idx == '0) begin
              crc_valid_o <= 1'b0;
              crc_bit_o   <= 1'b0;
              done_o      <= 1'b1;
              state       <= IDLE;
            end else begin
              emit_idx  <= emit_idx - 1'b1;
              crc_bit_o <= crc_o[emit_idx - 1'b1];
            end
          end
          default: ;  // IDLE: inputs ignored, register holds
        endcase
      end

      if (complete) begin
        if (mode_eff == CRC_MODE_GEN) begin
          crc_o       <= step_next;
          emit_idx    <= IDX_W'(CRC_W - 1);
          crc_bit_o   <= step_next[CRC_W-1];
          crc_valid_o <= 1'b1;
          state       <= EMIT;
        end else begin
          match_o <= (step_next == '0);
          done_o  <= 1'b1;
          state   <= IDLE;
        end
      end
    end
  end

endmodule : crc_serial_engine

// File: tb/tb_crc_serial_engine.sv
// -----------------------------------------------------------------------------
// tb_crc_serial_engine
// Directed bench for crc_serial_engine. A 5-bit instance (POLY=5'h05, INIT=0)
// carries the hand-computed vectors; a default CRC-24 instance shares the same
// inputs and is used for the seed-load check.
// Build with CRC_SEED_PORT_EN defined to also exercise the seed_i port.
// -----------------------------------------------------------------------------
module tb_crc_serial_engine;
  import crc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, mode, valid, data, last;

  logic        busy5, crc_bit5, crc_valid5, done5, match5;
  logic [4:0]  crc5;
  logic        busy24, crc_bit24, crc_valid24, done24, match24;
  logic [23:0] crc24;

`ifdef CRC_SEED_PORT_EN
  logic [4:0]  seed5  = 5'h00;
  logic [23:0] seed24 = 24'h555555;
`endif

  crc_serial_engine #(.CRC_W(5), .POLY(5'h05), .INIT(5'h00)) dut5 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .mode_i      (mode),
`ifdef CRC_SEED_PORT_EN
    .seed_i      (seed5),
`endif
    .valid_i     (valid),
    .data_i      (data),
    .last_i      (last),
    .busy_o      (busy5),
    .crc_o       (crc5),
    .crc_bit_o   (crc_bit5),
    .crc_valid_o (crc_valid5),
    .done_o      (done5),
    .match_o     (match5)
  );

  crc_serial_engine dut24 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .mode_i      (mode),
`ifdef CRC_SEED_PORT_EN
    .seed_i      (seed24),
`endif
    .valid_i     (valid),
    .data_i      (data),
    .last_i      (last),
    .busy_o      (busy24),
    .crc_o       (crc24),
    .crc_bit_o   (crc_bit24),
    .crc_valid_o (crc_valid24),
    .done_o      (done24),
    .match_o     (match24)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Bench-side view of the held result registers of the 5-bit instance.
  logic [4:0] exp_crc   = 5'h00;
  logic       exp_match = 1'b0;

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] bits;
    int          nbits;
    logic [4:0]  crc;    // expected crc_o (generate frames)
    logic        match;  // expected match_o (check frames)
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0;
    valid = 1'b0;
    data  = 1'b0;
    last  = 1'b0;
  endtask

  // start_i in its own cycle, then n bits MSB first; returns just after the
  // edge that took the last bit.
  task automatic drive_frame(input logic m, input logic [31:0] bits, input int n);
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      valid = 1'b1;
      data  = bits[i];
      last  = (i == 0);
      step();
    end
    clear_inputs();
  endtask

  // Called just after the completing edge of a generate frame.
  task automatic expect_emit(input logic [4:0] exp, input string tag);
    exp_crc = exp;
    check({tag, " crc_o"}, 32'(crc5), 32'(exp_crc));
    check({tag, " match_o held"}, 32'(match5), 32'(exp_match));
    for (int k = 4; k >= 0; k--) begin
      check({tag, " crc_valid"}, 32'(crc_valid5), 32'd1);
      check({tag, " crc_bit"}, 32'(crc_bit5), 32'(exp[k]));
      check({tag, " no early done"}, 32'(done5), 32'd0);
      step();
    end
    check({tag, " done pulse"}, 32'(done5), 32'd1);
    check({tag, " crc_valid off"}, 32'(crc_valid5), 32'd0);
    check({tag, " idle"}, 32'(busy5), 32'd0);
    step();
    check({tag, " done single"}, 32'(done5), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"gen12",    CRC_MODE_GEN, 32'b1010_0110_0000,        12, 5'b10000, 1'b0};
    vecs[1] = '{"chk17",    CRC_MODE_CHK, 32'b1010_0110_0000_10000,  17, 5'b00000, 1'b1};
    vecs[2] = '{"chk17bad", CRC_MODE_CHK, 32'b1010_0110_0000_10001,  17, 5'b00000, 1'b0};
    vecs[3] = '{"gen11",    CRC_MODE_GEN, 32'b11,                     2, 5'b01111, 1'b0};
    vecs[4] = '{"chk0",     CRC_MODE_CHK, 32'b0,                      1, 5'b00000, 1'b1};
    vecs[5] = '{"gen1",     CRC_MODE_GEN, 32'b1,                      1, 5'b00101, 1'b0};

    rst_n = 1'b0;
    mode  = 1'b0;
    clear_inputs();
    step();
    step();

    // Post-reset state
    check("rst crc_o",      32'(crc5),       32'd0);
    check("rst match_o",    32'(match5),     32'd0);
    check("rst busy_o",     32'(busy5),      32'd0);
    check("rst crc_valid",  32'(crc_valid5), 32'd0);
    check("rst crc_bit",    32'(crc_bit5),   32'd0);
    check("rst done_o",     32'(done5),      32'd0);
    check("rst lfsr24",     32'(dut24.lfsr), 32'h555555);

    // Default config: start with no data loads the seed, result untouched
    rst_n = 1'b1;
    step();
    start = 1'b1;
    mode  = CRC_MODE_GEN;
    step();
    start = 1'b0;
    check("start24 lfsr",  32'(dut24.lfsr), 32'h555555);
    check("start24 crc_o", 32'(crc24),      32'd0);
    check("start24 busy",  32'(busy24),     32'd1);

    // Table-driven frames on the 5-bit instance
    foreach (vecs[v]) begin
      drive_frame(vecs[v].mode, vecs[v].bits, vecs[v].nbits);
      if (vecs[v].mode == CRC_MODE_GEN) begin
        expect_emit(vecs[v].crc, vecs[v].name);
      end else begin
        exp_match = vecs[v].match;
        check({vecs[v].name, " done"},       32'(done5),  32'd1);
        check({vecs[v].name, " match_o"},    32'(match5), 32'(exp_match));
        check({vecs[v].name, " crc_o held"}, 32'(crc5),   32'(exp_crc));
        check({vecs[v].name, " idle"},       32'(busy5),  32'd0);
        step();
        check({vecs[v].name, " done single"}, 32'(done5), 32'd0);
      end
    end

    // IDLE ignores valid/last
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = i[0];
      last  = (i == 3);
      step();
      check("idle ignore busy", 32'(busy5), 32'd0);
      check("idle ignore done", 32'(done5), 32'd0);
    end
    clear_inputs();
    check("idle crc_o held", 32'(crc5), 32'(exp_crc));

    // Abort after 6 bits, then replay the full frame
    start = 1'b1;
    mode  = CRC_MODE_GEN;
    step();
    start = 1'b0;
    for (int i = 11; i >= 6; i--) begin
      valid = 1'b1;
      data  = vecs[0].bits[i];
      step();
    end
    clear_inputs();
    check("abort crc_o held", 32'(crc5), 32'(exp_crc));
    drive_frame(CRC_MODE_GEN, vecs[0].bits, 12);
    expect_emit(5'b10000, "replay");

    // start, valid and last together: single-bit frame from INIT
    start = 1'b1;
    mode  = CRC_MODE_GEN;
    valid = 1'b1;
    data  = 1'b1;
    last  = 1'b1;
    step();
    clear_inputs();
    expect_emit(5'b00101, "one-shot");

    // Reset in the middle of EMIT
    drive_frame(CRC_MODE_GEN, vecs[0].bits, 12);
    check("pre-rst crc_valid", 32'(crc_valid5), 32'd1);
    step();
    step();
    rst_n = 1'b0;
    step();
    exp_crc   = 5'h00;
    exp_match = 1'b0;
    check("emit-rst crc_valid", 32'(crc_valid5), 32'd0);
    check("emit-rst busy",      32'(busy5),      32'd0);
    check("emit-rst done",      32'(done5),      32'd0);
    check("emit-rst crc_o",     32'(crc5),       32'(exp_crc));
    rst_n = 1'b1;
    step();
    check("post-rst done", 32'(done5), 32'd0);

`ifdef CRC_SEED_PORT_EN
    // Per-frame seed: seed 5'h1F, one data bit of 0
    seed5 = 5'h1F;
    drive_frame(CRC_MODE_GEN, 32'b0, 1);
    expect_emit(5'b11011, "seed");
    seed5 = 5'h00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_crc_serial_engine
